// File: rtl/data_bus_responder_pkg.sv
// Shared constants for the data-memory responder: MMIO register map,
// STATUS bit positions and the UART serializer state encoding.
package data_bus_responder_pkg;

    localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h1000_0000;

    localparam logic [3:0] REG_TXDATA = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CYCLE  = 4'h8;

    localparam int STATUS_FULL     = 0;
    localparam int STATUS_BUSY     = 1;
    localparam int STATUS_EMPTY    = 2;
    localparam int STATUS_OVERFLOW = 3;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_START,
        SER_DATA,
        SER_STOP
    } ser_state_t;

endpackage

// File: rtl/data_bus_responder_uart_tx_serializer.sv
// 8N1 UART transmit serializer: loads a byte on start while idle and shifts
// it out LSB first between a low start bit and a high stop bit.
module uart_tx_serializer import data_bus_responder_pkg::*; #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       tx
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    ser_state_t    state, state_n;
    logic [CW-1:0] tick, tick_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SER_IDLE;
            tick    <= '0;
            bit_idx <= '0;
        end else begin
            state   <= state_n;
            tick    <= tick_n;
            bit_idx <= bit_idx_n;
        end
    end

    always_ff @(posedge clk) begin
        shreg <= shreg_n;
    end

    always_comb begin
        state_n   = state;
        tick_n    = tick;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        busy      = (state != SER_IDLE);
        tx        = 1'b1;
        case (state)
            SER_IDLE: begin
                if (start) begin
                    shreg_n   = data;
                    tick_n    = '0;
                    bit_idx_n = '0;
                    state_n   = SER_START;
                end
            end
            SER_START: begin
                tx = 1'b0;
                if (tick == LAST) begin
                    tick_n  = '0;
                    state_n = SER_DATA;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            SER_DATA: begin
                tx = shreg[0];
                if (tick == LAST) begin
                    tick_n  = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_n = SER_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            SER_STOP: begin
                if (tick == LAST) begin
                    tick_n  = '0;
                    state_n = SER_IDLE;
                end else begin
                    tick_n = tick + 1'b1;
                end
            end
            default: state_n = SER_IDLE;
        endcase
    end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder: byte-masked word RAM plus an MMIO window with a
// cycle counter and a FIFO-buffered UART transmitter.
module data_bus_responder import data_bus_responder_pkg::*; #(
    parameter int          DATA_WORDS   = 1024,
    parameter logic [31:0] MMIO_BASE    = MMIO_BASE_DEFAULT,
    parameter int          FIFO_DEPTH   = 4,
    parameter int          CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    input  logic        read_enable,
    output logic [31:0] read_data,
    output logic        uart_tx
);

    localparam int          AW        = $clog2(DATA_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(4 * DATA_WORDS);
    localparam int          PW        = $clog2(FIFO_DEPTH);
    localparam logic [PW:0] DEPTH     = (PW + 1)'(FIFO_DEPTH);

    logic [1:0]    off;
    logic [3:0]    eff_mask;
    logic [31:0]   eff_data;
    logic          misaligned;
    logic          in_ram;
    logic          in_mmio;
    logic [3:0]    reg_sel;
    logic [AW-1:0] word_idx;

    assign off        = address[1:0];
    assign eff_mask   = write_mask << off;
    assign eff_data   = write_data << {off, 3'b000};
    assign misaligned = (write_mask == 4'b0011 && off == 2'd3) ||
                        (write_mask == 4'b1111 && off != 2'd0);
    assign in_ram     = (address < RAM_BYTES);
    assign in_mmio    = (address[31:4] == MMIO_BASE[31:4]);
    assign reg_sel    = {address[3:2], 2'b00};
    assign word_idx   = address[AW+1:2];

    logic [31:0] ram [DATA_WORDS];

    always_ff @(posedge clk) begin
        if (write_enable && in_ram && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_mask[b]) begin
                    ram[word_idx][8*b +: 8] <= eff_data[8*b +: 8];
                end
            end
        end
    end

    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          overflow;
    logic [31:0]   cycle;
    logic          ser_busy;
    logic          pop, push_req, push_ok, status_store;

    // A push into a full FIFO still fits when the serializer drains an entry in the same cycle.
    assign pop          = !ser_busy && (count != '0);
    assign push_req     = write_enable && in_mmio && (reg_sel == REG_TXDATA);
    assign push_ok      = push_req && ((count != DEPTH) || pop);
    assign status_store = write_enable && in_mmio && (reg_sel == REG_STATUS);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycle    <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop};
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end else if (status_store) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo[wr_ptr] <= write_data[7:0];
    end

    uart_tx_serializer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_serializer (
        .clk  (clk),
        .rst  (rst),
        .start(pop),
        .data (fifo[rd_ptr]),
        .busy (ser_busy),
        .tx   (uart_tx)
    );

    logic [31:0] status;

    always_comb begin
        status                  = '0;
        status[STATUS_FULL]     = (count == DEPTH);
        status[STATUS_BUSY]     = ser_busy;
        status[STATUS_EMPTY]    = (count == '0);
        status[STATUS_OVERFLOW] = overflow;
    end

    always_comb begin
        read_data = '0;
        if (read_enable) begin
            if (in_ram) begin
                read_data = ram[word_idx] >> {off, 3'b000};
            end else if (in_mmio) begin
                case (reg_sel)
                    REG_STATUS: read_data = status;
                    REG_CYCLE:  read_data = cycle;
                    default:    read_data = '0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed scenarios with literal expectations
// plus randomized bus traffic compared every cycle against a byte/queue model.
module tb_data_bus_responder;

    localparam int          DW  = 64;
    localparam int          FD  = 4;
    localparam int          CPB = 4;
    localparam int          RB  = 4 * DW;
    localparam logic [31:0] MB  = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic        write_enable = 1'b0;
    logic [3:0]  write_mask = 4'b1111;
    logic        read_enable = 1'b0;
    logic [31:0] read_data;
    logic        uart_tx;

    always #5 clk = ~clk;

    data_bus_responder #(
        .DATA_WORDS  (DW),
        .MMIO_BASE   (MB),
        .FIFO_DEPTH  (FD),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .write_data  (write_data),
        .write_enable(write_enable),
        .write_mask  (write_mask),
        .read_enable (read_enable),
        .read_data   (read_data),
        .uart_tx     (uart_tx)
    );

    int checks = 0;
    int failures = 0;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: RAM as bytes, TX FIFO as a queue, serializer as a frame timeline.
    logic [7:0]  mram [RB];
    bit          mknown [RB];
    logic [31:0] m_cycle;
    logic [7:0]  m_q [$];
    bit          m_busy = 0;
    logic [7:0]  m_frame;
    int          m_t = 0;
    bit          m_ovf = 0;
    bit          m_valid = 0;
    bit          m_pop, m_req, m_acc, m_mmio;
    int          m_size, m_sz;

    initial begin
        for (int i = 0; i < RB; i++) mknown[i] = 0;
    end

    function automatic logic m_tx();
        int k;
        if (!m_busy) return 1'b1;
        k = m_t / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_frame[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_status();
        return {28'd0, m_ovf, (m_q.size() == 0), m_busy, (m_q.size() == FD)};
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a, input logic re, output bit known);
        logic [31:0] w;
        logic [31:0] base;
        known = 1;
        if (!re) return 32'd0;
        if (a < RB) begin
            base = {a[31:2], 2'b00};
            for (int i = 0; i < 4; i++) begin
                w[8*i +: 8] = mram[base + i];
                if (!mknown[base + i]) known = 0;
            end
            return w >> (8 * a[1:0]);
        end
        if (a[31:4] == MB[31:4]) begin
            case (a[3:2])
                2'd1:    return m_status();
                2'd2:    return m_cycle;
                default: return 32'd0;
            endcase
        end
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        m_mmio = (address[31:4] == MB[31:4]);
        if (rst) begin
            m_cycle = 0;
            m_q.delete();
            m_busy = 0;
            m_t = 0;
            m_ovf = 0;
            m_valid = 1;
        end else begin
            m_cycle = m_cycle + 1;
            m_sz = m_q.size();
            m_pop = !m_busy && m_sz > 0;
            m_req = write_enable && m_mmio && address[3:2] == 2'd0;
            m_acc = m_req && (m_sz < FD || m_pop);
            if (m_busy) begin
                if (m_t == 10 * CPB - 1) m_busy = 0;
                else m_t++;
            end else if (m_pop) begin
                m_frame = m_q.pop_front();
                m_busy = 1;
                m_t = 0;
            end
            if (m_acc) m_q.push_back(write_data[7:0]);
            if (m_req && !m_acc) m_ovf = 1;
            else if (write_enable && m_mmio && address[3:2] == 2'd1) m_ovf = 0;
            if (write_enable && address < RB) begin
                m_size = (write_mask == 4'b1111) ? 4 : (write_mask == 4'b0011) ? 2 : 1;
                if (!(m_size == 4 && address[1:0] != 2'd0) && !(m_size == 2 && address[1:0] == 2'd3)) begin
                    for (int i = 0; i < m_size; i++) begin
                        mram[address + i] = write_data[8*i +: 8];
                        mknown[address + i] = 1;
                    end
                end
            end
        end
    end

    bit          cmp_known;
    logic [31:0] cmp_exp;

    always @(negedge clk) begin
        if (m_valid) begin
            cmp_exp = m_read(address, read_enable, cmp_known);
            check1("uart_tx", uart_tx, m_tx());
            if (cmp_known) check32("read_data", read_data, cmp_exp);
        end
    end

    // Line decoder: samples mid-bit after each falling start edge.
    logic [7:0] rx_q [$];
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                repeat (5) @(negedge clk);
                b[0] = uart_tx;
                for (int i = 1; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    b[i] = uart_tx;
                end
                repeat (4) @(negedge clk);
                rx_q.push_back(b);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        write_enable = 1'b0;
        read_enable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        address = a;
        write_data = d;
        write_mask = m;
        write_enable = 1'b1;
        read_enable = 1'b0;
        cyc();
        write_enable = 1'b0;
    endtask

    task automatic rd_lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        address = a;
        read_enable = 1'b1;
        write_enable = 1'b0;
        @(negedge clk);
        check32(nm, read_data, e);
        cyc();
        read_enable = 1'b0;
    endtask

    initial begin
        logic [9:0] fr;
        logic [7:0] exp_b [5];
        int sel;

        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (10) cyc();
        address = MB + 32'h8;
        read_enable = 1'b1;
        @(negedge clk);
        check32("cycle_at_10", read_data, 32'd10);
        check1("idle_tx", uart_tx, 1'b1);
        cyc();
        rd_lit("status_reset", MB + 32'h4, 32'h4);

        wr(32'h10, 32'hDEADBEEF, 4'b1111);
        rd_lit("word_rd", 32'h10, 32'hDEADBEEF);
        wr(32'h11, 32'h00000055, 4'b0001);
        rd_lit("byte_merge", 32'h10, 32'hDEAD55EF);
        rd_lit("load_off3", 32'h13, 32'h000000DE);
        wr(32'h10, 32'hDEADBEEF, 4'b1111);
        wr(32'h12, 32'h00001234, 4'b0011);
        rd_lit("half_merge", 32'h10, 32'h1234BEEF);
        wr(32'h13, 32'h0000ABCD, 4'b0011);
        rd_lit("half_off3_drop", 32'h10, 32'h1234BEEF);
        wr(32'h12, 32'hCAFEF00D, 4'b1111);
        rd_lit("word_off2_load", 32'h12, 32'h00001234);
        rd_lit("unmapped_rd", 32'h2000_0000, 32'h0);
        rd_lit("txdata_rd", MB, 32'h0);
        rd_lit("reserved_rd", MB + 32'hC, 32'h0);

        wr(MB, 32'h000000A5, 4'b0001);
        address = MB + 32'h4;
        read_enable = 1'b1;
        @(negedge clk);
        check1("pre_frame_tx", uart_tx, 1'b1);
        check32("pre_frame_status", read_data, 32'h0);
        cyc();
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < CPB; j++) begin
                @(negedge clk);
                check1("frame_a5_bit", uart_tx, fr[i]);
                check1("frame_a5_busy", read_data[1], 1'b1);
            end
        end
        @(negedge clk);
        check1("post_frame_tx", uart_tx, 1'b1);
        check32("post_frame_status", read_data, 32'h4);
        cyc();
        bus_idle();

        rx_q.delete();
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int k = 0; k < 5; k++) wr(MB, {24'd0, exp_b[k]}, 4'b0001);
        rd_lit("status_full_busy", MB + 32'h4, 32'h3);
        wr(MB, 32'h00000066, 4'b0001);
        rd_lit("status_overflow", MB + 32'h4, 32'hB);
        wr(MB + 32'h4, 32'h0, 4'b1111);
        rd_lit("status_ovf_clear", MB + 32'h4, 32'h3);
        repeat (240) cyc();
        check32("frames_emitted", 32'(rx_q.size()), 32'd5);
        for (int k = 0; k < 5 && k < rx_q.size(); k++) begin
            check32("frame_byte", {24'd0, rx_q[k]}, {24'd0, exp_b[k]});
        end

        wr(MB, 32'h0000003C, 4'b0001);
        repeat (8) cyc();
        rst = 1'b1;
        address = MB + 32'h4;
        read_enable = 1'b1;
        cyc();
        @(negedge clk);
        check1("reset_mid_tx", uart_tx, 1'b1);
        check32("reset_mid_status", read_data, 32'h4);
        cyc();
        rst = 1'b0;
        address = MB + 32'h8;
        @(negedge clk);
        check32("cycle_after_rst", read_data, 32'h0);
        cyc();
        bus_idle();

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                bus_idle();
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end else begin
                sel = $urandom_range(0, 9);
                case (sel)
                    0, 1, 2, 3, 4: address = $urandom_range(0, 63);
                    5:             address = RB - 4 + $urandom_range(0, 3);
                    6, 7, 8:       address = MB + $urandom_range(0, 15);
                    default: begin
                        case ($urandom_range(0, 3))
                            0:       address = RB + $urandom_range(0, 255);
                            1:       address = MB + 32'h10 + $urandom_range(0, 255);
                            2:       address = 32'hFFFF_FFFC;
                            default: address = MB - 32'h4;
                        endcase
                    end
                endcase
                case ($urandom_range(0, 2))
                    0:       write_mask = 4'b0001;
                    1:       write_mask = 4'b0011;
                    default: write_mask = 4'b1111;
                endcase
                write_data = $urandom;
                write_enable = ($urandom_range(0, 2) == 0);
                read_enable = ($urandom_range(0, 1) == 1);
                cyc();
            end
        end
        bus_idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
Responder end of the core's data-memory port. Services the load/store requests the pipeline issues in its MEM stage: byte-masked word RAM, plus a small MMIO window holding a free-running cycle counter and a buffered 8N1 UART transmitter. Sits beside the core at top level; instruction fetch is served elsewhere.

Parameters:
DATA_WORDS, 1024, RAM depth in 32-bit words; RAM occupies byte addresses 0 .. 4*DATA_WORDS-1
MMIO_BASE, 32'h1000_0000, base byte address of the MMIO window
FIFO_DEPTH, 4, TX FIFO entries; power of two, at least 2
CLKS_PER_BIT, 868, clocks per UART bit; at least 2

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
address  input  32  byte address from core (MEM-stage ALU result)
write_data  input  32  store data, unshifted; valid bytes in low lanes
write_enable  input  1  store request this cycle
write_mask  input  4  unshifted lane mask: 0001 byte, 0011 half, 1111 word
read_enable  input  1  load request this cycle
read_data  output  32  load data, combinational, right-aligned
uart_tx  output  1  serial line, idle high

Behaviour:
- Reset: RAM contents not cleared; cycle counter=0; FIFO empty; serializer IDLE; overflow flag=0; uart_tx=1. read_data is combinational and depends only on address, read_enable and current state.
- Lane alignment: off=address[1:0]. Effective mask = write_mask<<off (4-bit, truncated); effective data = write_data<<(8*off). Misaligned access: half at off=3, or word at off!=0. A misaligned store is dropped. A misaligned load returns the shifted word, zero-filled from the top.
- Loads: read_data = (selected word)>>(8*off) when read_enable=1, else 0. Zero latency, no wait states. The core samples read_data in the same cycle and performs sign/zero extension itself.
- RAM region (address < 4*DATA_WORDS): word index address[31:2]. A store writes only the effective-mask lanes at the clock edge. A load in the same cycle as a store to the same word returns the old contents.
- MMIO, decoded on address[31:4]==MMIO_BASE[31:4]:
  - +0x0 TXDATA (W): pushes write_data[7:0] into the FIFO. Reads return 0.
  - +0x4 STATUS (R): bit0 fifo_full, bit1 tx_busy (serializer not IDLE), bit2 fifo_empty, bit3 overflow; other bits 0. Any store here clears overflow.
  - +0x8 CYCLE (R): 32-bit counter, +1 every cycle, wraps at 2^32-1→0. Stores are ignored.
  - +0xC reserved: read 0, store ignored.
  - MMIO accesses ignore off and use full words.
- Unmapped addresses: read 0, stores ignored, no error signalled.
- FIFO: the serializer pops when it is IDLE and the FIFO is non-empty.
  - Push is accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - A rejected push sets overflow and drops the byte.
  - Overflow set and clear in the same cycle: set wins.
- Serializer FSM (sub-module): IDLE→START→DATA→STOP→IDLE.
  - IDLE: uart_tx=1.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles.
  - A pop in IDLE loads the shift register; START begins on the next cycle.
  - Back-to-back bytes: STOP→IDLE→pop→START, so one idle-high cycle separates consecutive frames.
- Reset mid-frame: uart_tx returns to 1 on the next edge, the FIFO is emptied, and the in-flight byte is lost.

Decomposition:
- Shared package: MMIO_BASE default, register offsets (TXDATA/STATUS/CYCLE), STATUS bit indices, and an enum for serializer states.
- One sub-module, uart_tx_serializer, with ports clk, rst, start, data[7:0], busy, tx.
- FIFO, RAM and decode stay inline.

Test Plan:
- Reset, then idle 10 cycles → uart_tx=1, CYCLE read at cycle 10 returns 10, STATUS returns 0x4.
- Word store 0xDEADBEEF @0x10 → word read @0x10 returns 0xDEADBEEF; byte store 0x55 @0x11 with mask 0001 → word @0x10 reads 0xDEAD55EF; load @0x13 returns 0x000000DE.
- Half store 0x1234 @0x12 → word @0x10 reads 0x1234BEEF; half store @0x13 is dropped and the word is unchanged.
- CLKS_PER_BIT=4, store 0xA5 to TXDATA → uart_tx low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles; STATUS.tx_busy=1 throughout the frame.
- CLKS_PER_BIT=4, six back-to-back TXDATA stores → first byte enters the serializer and four are queued, so STATUS=0x3; the sixth is rejected and sets overflow (STATUS=0xB); storing to STATUS clears bit3; exactly five frames are emitted, in order.
- Assert rst mid-DATA bit → next cycle uart_tx=1, STATUS=0x4, CYCLE reads 0 one cycle after rst deasserts.
